// File: rtl/mul_tree_pipe.sv
// Pipelined AND-array multiplier with a registered balanced adder tree.
// Optional signed mode: define MUL_TREE_PIPE_SIGNED_EN to add the in_signed port.
module mul_tree_pipe #(
    parameter int WIDTH_A = 8,
    parameter int WIDTH_B = 8,
    parameter int TAG_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
`ifdef MUL_TREE_PIPE_SIGNED_EN
    input  logic                       in_signed,
`endif
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH_A-1:0]         in_a,
    input  logic [WIDTH_B-1:0]         in_b,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH_A+WIDTH_B-1:0] out_product,
    output logic [TAG_W-1:0]           out_tag
);

    localparam int LEVELS = $clog2(WIDTH_B);
    localparam int PW     = WIDTH_A + WIDTH_B;
    localparam int HALF   = WIDTH_B / 2;

    logic               en;
    logic [WIDTH_A-1:0] s0_a;
    logic [WIDTH_B-1:0] s0_b;
    logic               vld [0:LEVELS];
    logic [TAG_W-1:0]   tg  [0:LEVELS];
    logic [PW-1:0]      rows [WIDTH_B];
    logic [PW-1:0]      lvl  [1:LEVELS][HALF];
`ifdef MUL_TREE_PIPE_SIGNED_EN
    logic               s0_sgn;
`endif

    assign out_valid   = vld[LEVELS];
    assign out_tag     = tg[LEVELS];
    assign out_product = lvl[LEVELS][0];

    // A stalled output freezes the whole pipe, so no skid buffer is needed.
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_a <= '0;
            s0_b <= '0;
`ifdef MUL_TREE_PIPE_SIGNED_EN
            s0_sgn <= 1'b0;
`endif
            for (int k = 0; k <= LEVELS; k++) begin
                vld[k] <= 1'b0;
                tg[k]  <= '0;
            end
        end else if (en) begin
            s0_a   <= in_a;
            s0_b   <= in_b;
            vld[0] <= in_valid;
            tg[0]  <= in_tag;
`ifdef MUL_TREE_PIPE_SIGNED_EN
            s0_sgn <= in_signed;
`endif
            for (int k = 1; k <= LEVELS; k++) begin
                vld[k] <= vld[k-1];
                tg[k]  <= tg[k-1];
            end
        end
    end

    always_comb begin
        logic [PW-1:0] ext;
        ext = {{WIDTH_B{1'b0}}, s0_a};
`ifdef MUL_TREE_PIPE_SIGNED_EN
        if (s0_sgn)
            ext = {{WIDTH_B{s0_a[WIDTH_A-1]}}, s0_a};
`endif
        for (int j = 0; j < WIDTH_B; j++) begin
            rows[j] = s0_b[j] ? (ext << j) : '0;
`ifdef MUL_TREE_PIPE_SIGNED_EN
            // The multiplier MSB carries weight -2^(WIDTH_B-1) in two's complement.
            if (s0_sgn && (j == WIDTH_B - 1))
                rows[j] = -rows[j];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= LEVELS; k++)
                for (int i = 0; i < HALF; i++)
                    lvl[k][i] <= '0;
        end else if (en) begin
            for (int i = 0; i < HALF; i++)
                lvl[1][i] <= rows[2*i] + rows[2*i+1];
            for (int k = 2; k <= LEVELS; k++)
                for (int i = 0; i < (WIDTH_B >> k); i++)
                    lvl[k][i] <= lvl[k-1][2*i] + lvl[k-1][2*i+1];
        end
    end

endmodule

// File: tb/tb_mul_tree_pipe.sv
// Bench for mul_tree_pipe: directed latency/stream/stall/reset steps plus
// randomized traffic against an arithmetic product model and FIFO scoreboard.
module tb_mul_tree_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  in_a, in_b;
    logic [3:0]  in_tag, out_tag;
    logic [15:0] out_product;
    logic        sgn;

    logic        v5, r5, ov5;
    logic [11:0] a5;
    logic [3:0]  b5, t5, ot5;
    logic [15:0] p5;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [15:0] qp [$];
    logic [3:0]  qt [$];
    bit          stall_prev = 0;
    logic [15:0] held_p;
    logic [3:0]  held_t;

    always #5 clk = ~clk;

    mul_tree_pipe #(.WIDTH_A(8), .WIDTH_B(8), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef MUL_TREE_PIPE_SIGNED_EN
        .in_signed(sgn),
`endif
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .out_tag(out_tag)
    );

    mul_tree_pipe #(.WIDTH_A(12), .WIDTH_B(4), .TAG_W(4)) dut5 (
        .clk(clk), .rst_n(rst_n),
`ifdef MUL_TREE_PIPE_SIGNED_EN
        .in_signed(1'b0),
`endif
        .in_valid(v5), .in_ready(r5),
        .in_a(a5), .in_b(b5), .in_tag(t5),
        .out_valid(ov5), .out_ready(1'b1),
        .out_product(p5), .out_tag(ot5)
    );

    function automatic logic [15:0] model(logic [7:0] a, logic [7:0] b, bit s);
        int ia, ib;
        ia = s ? int'($signed(a)) : int'(a);
        ib = s ? int'($signed(b)) : int'(b);
        return 16'(ia * ib);
    endfunction

    task automatic chk(string nm, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    task automatic cyc();
        bit ih, oh;
        #1;
        ih = in_valid && in_ready;
        oh = out_valid && out_ready;
        chk("in_ready", in_ready, !(out_valid && !out_ready));
        if (stall_prev) begin
            chk("hold_product", out_product, held_p);
            chk("hold_tag", out_tag, held_t);
        end
        if (oh) begin
            if (qp.size() == 0) chk("spurious_out", out_valid, 0);
            else begin
                chk("product", out_product, qp.pop_front());
                chk("tag", out_tag, qt.pop_front());
                pops++;
            end
        end
        stall_prev = out_valid && !out_ready;
        held_p = out_product;
        held_t = out_tag;
        if (ih) begin
            qp.push_back(model(in_a, in_b, sgn));
            qt.push_back(in_tag);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic lat(logic [7:0] a, logic [7:0] b, logic [3:0] t);
        in_valid = 1; in_a = a; in_b = b; in_tag = t;
        cyc();
        in_valid = 0;
        for (int n = 1; n <= 4; n++) begin
            chk("latency_valid", out_valid, n == 4);
            if (n < 4) cyc();
        end
        cyc();
    endtask

    initial begin
        rst_n = 0; in_valid = 0; in_a = 0; in_b = 0; in_tag = 0;
        out_ready = 1; sgn = 0;
        v5 = 0; a5 = 0; b5 = 0; t5 = 0;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_product", out_product, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_valid5", ov5, 0);
        rst_n = 1;
        @(posedge clk); #1;

        lat(8'hFF, 8'hFF, 4'd3);
        chk("test1_empty", qp.size(), 0);

        pops = 0;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1; in_a = 8'(i); in_b = 8'd3; in_tag = 4'(i);
            cyc();
        end
        in_valid = 0;
        for (int i = 0; i < 4; i++) cyc();
        chk("stream_no_gaps", pops, 16);

        for (int i = 0; i < 12; i++) begin
            in_valid = 1; in_a = 8'($urandom); in_b = 8'($urandom);
            in_tag = 4'($urandom);
            out_ready = !(i >= 6 && i < 9);
            cyc();
        end
        in_valid = 0; out_ready = 1;
        for (int i = 0; i < 6; i++) cyc();
        chk("stall_drain", qp.size(), 0);

        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_a = 8'(i + 5); in_b = 8'd7; in_tag = 4'(i);
            cyc();
        end
        in_valid = 0;
        rst_n = 0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_product", out_product, 0);
        qp.delete(); qt.delete(); stall_prev = 0;
        @(posedge clk); #1;
        rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            chk("post_rst_idle", out_valid, 0);
            cyc();
        end
        lat(8'd200, 8'd100, 4'd9);

        v5 = 1; a5 = 12'hFFF; b5 = 4'hF; t5 = 4'd6;
        @(posedge clk); #1;
        v5 = 0;
        for (int n = 1; n <= 3; n++) begin
            chk("w12_valid", ov5, n == 3);
            if (n < 3) begin @(posedge clk); #1; end
        end
        chk("w12_product", p5, 16'hEFF1);
        chk("w12_tag", ot5, 6);

`ifdef MUL_TREE_PIPE_SIGNED_EN
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; sgn = (i < 2);
            in_a = (i == 0 || i == 2) ? 8'h80 : 8'hFF;
            in_b = (i == 0 || i == 2) ? 8'h80 : 8'h01;
            in_tag = 4'(i);
            cyc();
        end
        in_valid = 0; sgn = 0;
        for (int i = 0; i < 5; i++) cyc();
        chk("signed_drain", qp.size(), 0);
`endif

        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_a = 8'($urandom); in_b = 8'($urandom); in_tag = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
`ifdef MUL_TREE_PIPE_SIGNED_EN
            sgn = 1'($urandom);
`endif
            cyc();
        end
        in_valid = 0; out_ready = 1;
        for (int i = 0; i < 8; i++) cyc();
        chk("random_drain", qp.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
